// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
// The optional signed mode is enabled by defining MULDIV_SIGNED_EN.
package muldiv_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = $clog2(XLEN_DEF);

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic op_is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Two's-complement helpers for the multiply/divide unit: operand magnitudes at
// acceptance and result negation on the way into DONE (MULDIV_SIGNED_EN only).
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            op_signed,
    input  op_t             op_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_q,
    output logic            neg_r,
    input  op_t             res_op,
    input  logic            res_neg_q,
    input  logic            res_neg_r,
    input  logic [XLEN-1:0] raw,
    input  logic            lo_zero,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic            sa_s;
    logic            sb_s;
    logic            neg_s;
    logic [XLEN-1:0] neg_val_s;

    // Operand magnitudes and result signs; a zero divisor keeps the all-ones quotient.
    always_comb begin
        sa_s  = op_signed & op_a[XLEN-1];
        sb_s  = op_signed & op_b[XLEN-1];
        mag_a = sa_s ? (~op_a + ONE) : op_a;
        mag_b = sb_s ? (~op_b + ONE) : op_b;
        neg_q = (sa_s ^ sb_s) & (!op_is_div(op_in) | (op_b != {XLEN{1'b0}}));
        neg_r = sa_s;
    end

    // MULH negation of the full product only carries into the high half when the low half is zero.
    always_comb begin
        if (res_op == OP_MULH) begin
            neg_val_s = ~raw + {{(XLEN-1){1'b0}}, lo_zero};
        end else begin
            neg_val_s = ~raw + ONE;
        end
        neg_s  = (res_op == OP_REM) ? res_neg_r : res_neg_q;
        result = neg_s ? neg_val_s : raw;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative XLEN-bit multiply/divide unit with a one-cycle register-bank write-back.
// Define MULDIV_SIGNED_EN to honour op_signed (two's-complement operation).
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              op_signed,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic [REG_AW-1:0] rd_in,
    output logic              ready,
    output logic              busy,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] wb_reg,
    output logic              wb_we
);

    localparam int CNT_W = (XLEN == XLEN_DEF) ? CNT_W_DEF : $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state_r;
    op_t               op_r;
    op_t               op_in_s;
    logic [REG_AW-1:0] rd_r;
    logic [XLEN-1:0]   d_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              last_r;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [XLEN-1:0]   raw_s;
    logic [XLEN-1:0]   res_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     shifted_s;
    logic              ge_s;
    logic [XLEN-1:0]   hi_nx_s;
    logic [XLEN-1:0]   lo_nx_s;

    assign op_in_s = op_t'(op);

`ifdef MULDIV_SIGNED_EN
    logic neg_q_s;
    logic neg_r_s;
    logic neg_q_r;
    logic neg_r_r;

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .op_signed (op_signed),
        .op_in     (op_in_s),
        .op_a      (op_a),
        .op_b      (op_b),
        .mag_a     (mag_a_s),
        .mag_b     (mag_b_s),
        .neg_q     (neg_q_s),
        .neg_r     (neg_r_s),
        .res_op    (op_r),
        .res_neg_q (neg_q_r),
        .res_neg_r (neg_r_r),
        .raw       (raw_s),
        .lo_zero   (lo_r == {XLEN{1'b0}}),
        .result    (res_s)
    );

    // Result sign flags captured with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            neg_q_r <= neg_q_s;
            neg_r_r <= neg_r_s;
        end else begin
            neg_q_r <= neg_q_r;
            neg_r_r <= neg_r_r;
        end
    end
`else
    logic unused_s;

    assign mag_a_s  = op_a;
    assign mag_b_s  = op_b;
    assign res_s    = raw_s;
    assign unused_s = op_signed;
`endif

    // One iteration: shift-add for multiply, restoring subtract for divide (hi=remainder, lo=quotient).
    always_comb begin
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, d_r} : {(XLEN+1){1'b0}});
        shifted_s = {hi_r, lo_r[XLEN-1]};
        ge_s      = shifted_s >= {1'b0, d_r};
        if (op_is_div(op_r)) begin
            hi_nx_s = ge_s ? (shifted_s[XLEN-1:0] - d_r) : shifted_s[XLEN-1:0];
            lo_nx_s = {lo_r[XLEN-2:0], ge_s};
        end else begin
            hi_nx_s = sum_s[XLEN:1];
            lo_nx_s = {sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Unsigned result selection from the product / remainder:quotient pair.
    always_comb begin
        case (op_r)
            OP_MUL:  raw_s = lo_r;
            OP_MULH: raw_s = hi_r;
            OP_DIV:  raw_s = lo_r;
            OP_REM:  raw_s = hi_r;
            default: raw_s = lo_r;
        endcase
    end

    // Control FSM, datapath registers and registered write-back outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            wb_we   <= 1'b0;
            wb_data <= {XLEN{1'b0}};
            wb_reg  <= {REG_AW{1'b0}};
            op_r    <= OP_MUL;
            rd_r    <= {REG_AW{1'b0}};
            d_r     <= {XLEN{1'b0}};
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= {XLEN{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wb_we <= 1'b0;
                    if (start) begin
                        state_r <= CALC;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        op_r    <= op_in_s;
                        rd_r    <= rd_in;
                        d_r     <= op_is_div(op_in_s) ? mag_b_s : mag_a_s;
                        lo_r    <= op_is_div(op_in_s) ? mag_a_s : mag_b_s;
                        hi_r    <= {XLEN{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        last_r  <= 1'b0;
                    end
                end
                CALC: begin
                    if (last_r) begin
                        state_r <= DONE;
                        wb_we   <= 1'b1;
                        wb_data <= res_s;
                        wb_reg  <= rd_r;
                    end else begin
                        hi_r   <= hi_nx_s;
                        lo_r   <= lo_nx_s;
                        cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        last_r <= (cnt_r == CNT_LAST);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    wb_we   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    wb_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, protocol sequences and
// random operations against a plain-arithmetic reference model.
module tb_mul_div_unit;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        op_signed;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [4:0]  rd_in;
    logic        ready;
    logic        busy;
    logic [63:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_we;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    mul_div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .op_signed (op_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .ready     (ready),
        .busy      (busy),
        .wb_data   (wb_data),
        .wb_reg    (wb_reg),
        .wb_we     (wb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic s,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic               sg;
        sg = s;
`ifndef MULDIV_SIGNED_EN
        sg = 1'b0;
`endif
        sa = a;
        sb = b;
        if (sg) p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        else    p = {64'd0, a} * {64'd0, b};
        case (o)
            2'd0: return p[63:0];
            2'd1: return p[127:64];
            2'd2: begin
                if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
                if (sg) return sa / sb;
                return a / b;
            end
            default: begin
                if (b == 64'd0) return a;
                if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 64'd0;
                if (sg) return sa % sb;
                return a % b;
            end
        endcase
    endfunction

    task automatic add_vec(input logic [1:0] o, input logic s, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
        vec_t v;
        v.op = o; v.sgn = s; v.a = a; v.b = b; v.rd = rd; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Issue one operation and watch 70 edges: latency, single pulse, ready profile, result and hold.
    task automatic run_op(input string nm, input vec_t v, input bit poke);
        int          first;
        int          pulses;
        int          rdy_err;
        logic [63:0] got;
        logic [4:0]  greg;
        first = -1; pulses = 0; rdy_err = 0; got = 64'd0; greg = 5'd0;
        @(negedge clk);
        start = 1'b1; op = v.op; op_signed = v.sgn; op_a = v.a; op_b = v.b; rd_in = v.rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); op_signed = 1'($urandom_range(0, 1));
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; rd_in = 5'($urandom_range(0, 31));
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (poke) start = (n == 20) || (n == 65);
            if (wb_we) begin
                pulses++;
                if (first < 0) begin
                    first = n; got = wb_data; greg = wb_reg;
                end
            end
            if (ready !== (n >= 66)) rdy_err++;
            if (busy !== !ready) rdy_err++;
        end
        start = 1'b0;
        check({nm, " latency"}, 64'(first), 64'd65);
        check({nm, " pulses"}, 64'(pulses), 64'd1);
        check({nm, " data"}, got, v.exp);
        check({nm, " reg"}, {59'd0, greg}, {59'd0, v.rd});
        check({nm, " ready"}, 64'(rdy_err), 64'd0);
        check({nm, " hold"}, wb_data, v.exp);
    endtask

    initial begin
        int   cnt;
        vec_t v;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; op_signed = 1'b0;
        op_a = 64'd0; op_b = 64'd0; rd_in = 5'd0;
        #12;
        check("rst ready", {63'd0, ready}, 64'd1);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst we", {63'd0, wb_we}, 64'd0);
        check("rst data", wb_data, 64'd0);
        check("rst reg", {59'd0, wb_reg}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (wb_we) cnt++;
        end
        check("idle we", 64'(cnt), 64'd0);

        add_vec(2'd0, 1'b0, 64'd7, 64'd6, 5'd5, 64'd42);
        add_vec(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        add_vec(2'd2, 1'b0, 64'd100, 64'd7, 5'd31, 64'd14);
        add_vec(2'd3, 1'b0, 64'd100, 64'd7, 5'd0, 64'd2);
        add_vec(2'd2, 1'b0, 64'd9, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(2'd3, 1'b0, 64'd9, 64'd0, 5'd13, 64'd9);
`ifdef MULDIV_SIGNED_EN
        add_vec(2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        add_vec(2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(2'd2, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'h8000_0000_0000_0000);
        add_vec(2'd3, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'd0);
        add_vec(2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec(2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFB);
`else
        add_vec(2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 64'h7FFF_FFFF_FFFF_FFFC);
        add_vec(2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 64'd0);
`endif
        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Extra start pulses during CALC and in the DONE cycle must be ignored.
        v.op = 2'd0; v.sgn = 1'b0; v.a = 64'd7; v.b = 64'd6; v.rd = 5'd5; v.exp = 64'd42;
        run_op("poke", v, 1'b1);

        // Reset at edge 30 of a divide discards the operation.
        @(negedge clk);
        start = 1'b1; op = 2'd2; op_signed = 1'b0; op_a = 64'd100; op_b = 64'd7; rd_in = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst we", {63'd0, wb_we}, 64'd0);
        check("midrst ready", {63'd0, ready}, 64'd1);
        check("midrst busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (wb_we) cnt++;
        end
        check("midrst no we", 64'(cnt), 64'd0);
        v.op = 2'd0; v.sgn = 1'b0; v.a = 64'd3; v.b = 64'd3; v.rd = 5'd17; v.exp = 64'd9;
        run_op("after rst", v, 1'b0);

        for (int i = 0; i < 24; i++) begin
            v.op  = 2'($urandom_range(0, 3));
            v.sgn = 1'($urandom_range(0, 1));
            v.a   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       v.b = 64'd0;
                1:       v.b = 64'($urandom_range(1, 1000));
                2:       v.b = {32'd0, $urandom};
                default: v.b = {$urandom, $urandom};
            endcase
            if (i == 5) v.a = 64'd0;
            v.rd  = 5'($urandom_range(0, 31));
            v.exp = ref_model(v.op, v.sgn, v.a, v.b);
            run_op($sformatf("rand%0d op%0d s%0d", i, v.op, v.sgn), v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
